mac_tree_ctrl: RTL and testbench
================================

Name: mac_tree_ctrl

Overview:
Sequencer for the 8x8 Wallace reduction tree. It accepts operand pairs over a valid/ready stream and drives the eight partial-product rows into the tree. It resolves the tree's sum and carry vectors with a final carry-propagate add and accumulates a programmed number of products. The finished dot-product is returned on an output handshake. It sits between the job/operand source and the combinational reduction tree, which stays outside this block.

Parameters:
ACC_W, 24, accumulator width in bits; must be at least 16.
LEN_W, 8, width of the job-length field.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  job start pulse; sampled in IDLE only
len  in  LEN_W  number of products in the job
abort  in  1  cancel the current job
in_valid  in  1  operand pair valid
in_ready  out  1  operand pair accepted when in_valid && in_ready
in_a  in  8  multiplicand
in_b  in  8  multiplier
pp1..pp8  out  8 each  partial-product rows to the tree; ppk = in_a & {8{in_b[k-1]}}
tree_s  in  15  tree sum vector; bit i has weight 2^i
tree_c  in  11  tree carry vector; bit i has weight 2^(i+5)
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid && out_ready
out_acc  out  ACC_W  accumulated result
out_ovf  out  1  sticky accumulator overflow flag
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; pp1..pp8, product register, acc, cnt, v1, v2, out_ovf all 0. Therefore out_valid=0, in_ready=0, busy=0.
- States and transitions:
  - IDLE: on start with len==0, go to DONE with acc=0. On start with len!=0, go to RUN with acc=0, ovf=0, cnt=len.
  - RUN: in_ready=1. Each handshake registers pp1..pp8, sets v1=1 and decrements cnt. The handshake that takes cnt to 0 moves the state to DRAIN.
  - DRAIN: in_ready=0. Move to DONE on the first edge where v1=0 and v2=0.
  - DONE: out_valid=1 and out_acc=acc. On out_ready, go to IDLE.
- Pipeline stages:
  - Stage 1: pp registers, flag v1. v1 clears on any edge without a handshake.
  - Stage 2: product register = tree_s + (tree_c << 5), computed at 16 bits and registered when v1=1; sets v2.
  - Stage 3: when v2=1, acc <= acc + zero-extended product. A carry out of bit ACC_W-1 sets out_ovf; acc wraps modulo 2^ACC_W.
- Latency: out_valid rises 3 edges after the edge that accepts the last operand pair (DRAIN→DONE on the 3rd edge).
- Throughput: one product per cycle. in_valid gaps are allowed; the pipeline drains bubbles correctly.
- pp1..pp8 hold their last value between handshakes. The tree output is only consumed when v1=1.
- start is ignored outside IDLE. in_valid is ignored outside RUN.
- DONE holds out_acc and out_ovf stable while out_ready=0.
- abort has priority over everything:
  - Next edge: state=IDLE; v1, v2, acc, cnt, ovf and pp1..pp8 cleared.
  - A handshake or out_ready in the same cycle as abort is discarded.
  - abort in IDLE has no effect beyond the clears.
- out_ovf is reset only by reset, abort, or the start of a new job.

Decomposition:
- Package mac_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE}
  - PROD_W=16
  - CARRY_SHIFT=5
  - TREE_S_W=15, TREE_C_W=11
- One sub-module, mac_cpa: the combinational final adder, tree_s + (tree_c << CARRY_SHIFT) giving PROD_W bits.
- The FSM, counter and accumulator live in mac_tree_ctrl.
- The bench connects the team's existing Wallace reduction tree between pp1..pp8 and tree_s/tree_c.

Test Plan:
- Single product: len=1, in_a=3, in_b=5 → out_valid rises 3 edges after the accept; out_acc=15, out_ovf=0.
- Max operands: len=4, in_a=in_b=255 each cycle, back-to-back → out_acc=260100, out_ovf=0, in_ready=1 for exactly 4 cycles.
- Empty job: start with len=0 → DONE on the next edge, out_acc=0; out_ready returns the block to IDLE.
- Overflow: ACC_W=16, len=2, 255x255 twice → out_acc=64514, out_ovf=1.
- Stalls and backpressure: len=3 with (7,9), (128,2), (1,1) and one idle cycle between pairs, then out_ready low for 5 cycles → out_acc=320, stable for all 5 cycles; IDLE the edge after out_ready rises.
- Abort: len=4, abort after 2 accepts → IDLE next edge, in_ready=0, out_valid never asserts. A following job with len=1 and operands (2,3) → out_acc=6.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg: shared states and widths for the Wallace-tree MAC sequencer
package mac_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam int PROD_W = 16;
    localparam int CARRY_SHIFT = 5;
    localparam int TREE_S_W = 15;
    localparam int TREE_C_W = 11;
endpackage

// File: rtl/mac_cpa.sv
// mac_cpa: final carry-propagate add resolving the tree's sum and carry vectors
module mac_cpa import mac_pkg::*; (
    input  logic [TREE_S_W-1:0] s,
    input  logic [TREE_C_W-1:0] c,
    output logic [PROD_W-1:0]   sum
);
    assign sum = PROD_W'(s) + (PROD_W'(c) << CARRY_SHIFT);
endmodule

// File: rtl/mac_tree_ctrl.sv
// mac_tree_ctrl: operand sequencer, product pipeline and accumulator around an external Wallace tree
module mac_tree_ctrl import mac_pkg::*; #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [LEN_W-1:0]    len,
    input  logic                abort,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          in_a,
    input  logic [7:0]          in_b,
    output logic [7:0]          pp1,
    output logic [7:0]          pp2,
    output logic [7:0]          pp3,
    output logic [7:0]          pp4,
    output logic [7:0]          pp5,
    output logic [7:0]          pp6,
    output logic [7:0]          pp7,
    output logic [7:0]          pp8,
    input  logic [TREE_S_W-1:0] tree_s,
    input  logic [TREE_C_W-1:0] tree_c,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W-1:0]    out_acc,
    output logic                out_ovf,
    output logic                busy
);
    state_t state, state_n;
    logic [7:0][7:0] pp;
    logic [LEN_W-1:0] cnt;
    logic [PROD_W-1:0] prod, sum;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0] acc_sum;
    logic v1, v2, hs;

    mac_cpa u_cpa (.s(tree_s), .c(tree_c), .sum(sum));

    assign in_ready  = state == RUN;
    assign hs        = in_valid && in_ready;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    assign out_acc   = acc;
    assign acc_sum   = {1'b0, acc} + (ACC_W+1)'(prod);
    assign {pp8, pp7, pp6, pp5, pp4, pp3, pp2, pp1} = pp;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = len == '0 ? DONE : RUN;
            RUN:     if (hs && cnt == LEN_W'(1)) state_n = DRAIN;
            DRAIN:   if (!v1 && !v2) state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (abort) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pp      <= '0;
            prod    <= '0;
            acc     <= '0;
            cnt     <= '0;
            v1      <= 1'b0;
            v2      <= 1'b0;
            out_ovf <= 1'b0;
        end else if (abort) begin
            state   <= IDLE;
            pp      <= '0;
            acc     <= '0;
            cnt     <= '0;
            v1      <= 1'b0;
            v2      <= 1'b0;
            out_ovf <= 1'b0;
        end else begin
            state <= state_n;
            v1    <= hs;
            v2    <= v1;
            if (hs) begin
                for (int i = 0; i < 8; i++) pp[i] <= in_a & {8{in_b[i]}};
                cnt <= cnt - LEN_W'(1);
            end
            if (v1) prod <= sum;
            // a new job always starts from a clean accumulator and overflow flag
            if (state == IDLE && start) begin
                acc     <= '0;
                out_ovf <= 1'b0;
                cnt     <= len;
            end else if (v2) begin
                acc     <= acc_sum[ACC_W-1:0];
                out_ovf <= out_ovf | acc_sum[ACC_W];
            end
        end
    end
endmodule

// File: tb/tb_mac_tree_ctrl.sv
// tb_mac_tree_ctrl: table, hand-written and randomized checks of mac_tree_ctrl at ACC_W=24 and ACC_W=16
module tb_mac_tree_ctrl;
    logic clk = 1'b0, rst_n, start, abort, in_valid, out_ready;
    logic [7:0] len, in_a, in_b;
    logic [7:0] pp1, pp2, pp3, pp4, pp5, pp6, pp7, pp8;
    logic [7:0] qp1, qp2, qp3, qp4, qp5, qp6, qp7, qp8;
    logic [14:0] ts, ts_h;
    logic [10:0] tc, tc_h;
    logic in_ready, out_valid, out_ovf, busy;
    logic in_ready_h, out_valid_h, out_ovf_h, busy_h;
    logic [23:0] out_acc;
    logic [15:0] out_acc_h;
    logic [7:0] ja [16];
    logic [7:0] jb [16];
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    // behavioural stand-in for the reduction tree: any split with s + (c<<5) == product
    function automatic logic [25:0] tree(input logic [63:0] rows);
        int p, r, c;
        p = 0;
        for (int k = 0; k < 8; k++) p += int'(rows[8*k+:8]) << k;
        r = (p >> 5) / 2;
        c = (p >> 5) - r;
        return {15'(p - (c << 5)), 11'(c)};
    endfunction

    function automatic logic [63:0] rows_of(input logic [7:0] a, input logic [7:0] b);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k+:8] = b[k] ? a : 8'h00;
        return r;
    endfunction

    assign {ts, tc}     = tree({pp8, pp7, pp6, pp5, pp4, pp3, pp2, pp1});
    assign {ts_h, tc_h} = tree({qp8, qp7, qp6, qp5, qp4, qp3, qp2, qp1});

    mac_tree_ctrl #(.ACC_W(24), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .pp1(pp1), .pp2(pp2), .pp3(pp3), .pp4(pp4), .pp5(pp5), .pp6(pp6), .pp7(pp7), .pp8(pp8),
        .tree_s(ts), .tree_c(tc), .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_ovf(out_ovf), .busy(busy)
    );

    mac_tree_ctrl #(.ACC_W(16), .LEN_W(8)) dut_h (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready_h), .in_a(in_a), .in_b(in_b),
        .pp1(qp1), .pp2(qp2), .pp3(qp3), .pp4(qp4), .pp5(qp5), .pp6(qp6), .pp7(qp7), .pp8(qp8),
        .tree_s(ts_h), .tree_c(tc_h), .out_valid(out_valid_h), .out_ready(out_ready),
        .out_acc(out_acc_h), .out_ovf(out_ovf_h), .busy(busy_h)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int n, input int gap, input int hold, input bit rnd,
                           output logic [23:0] r24, output logic o24,
                           output logic [15:0] r16, output logic o16);
        int k, idle, cyc, rdy, lat, bad;
        logic hs;
        logic [23:0] h24;
        logic h_ovf;
        start = 1'b1;
        len = 8'(n);
        tick();
        start = 1'b0;
        len = 8'($urandom);
        if (n == 0) chk("empty_done", out_valid, 1);
        else begin
            k = 0; idle = 0; cyc = 0; rdy = 0;
            while (k < n && cyc < 2000) begin
                in_valid = idle == 0;
                in_a = ja[k];
                in_b = jb[k];
                if (rnd) start = 1'($urandom);
                rdy += int'(in_ready);
                hs = in_valid && in_ready;
                tick();
                cyc++;
                if (hs) begin
                    k++;
                    idle = gap < 0 ? int'($urandom_range(0, 2)) : gap;
                end else if (idle > 0) idle--;
            end
            start = 1'b0;
            in_valid = rnd ? 1'($urandom) : 1'b0;
            chk("accepts", k, n);
            chk("ready_cycles", rdy, cyc);
            chk("ready_drop", in_ready, 0);
            lat = 0;
            while (!out_valid && lat < 10) begin
                tick();
                lat++;
            end
            chk("latency", lat, 3);
        end
        chk("twin_match", {out_valid_h, in_ready_h}, {out_valid, in_ready});
        h24 = out_acc;
        h_ovf = out_ovf;
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (!out_valid || out_acc !== h24 || out_ovf !== h_ovf) bad++;
        end
        chk("hold_stable", bad, 0);
        r24 = out_acc; o24 = out_ovf; r16 = out_acc_h; o16 = out_ovf_h;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("idle_after", {busy, out_valid, busy_h}, 0);
        if (n > 0) chk("pp_hold", {pp8, pp7, pp6, pp5, pp4, pp3, pp2, pp1}, rows_of(ja[n-1], jb[n-1]));
    endtask

    typedef struct {
        int n, gap, hold;
        logic [31:0] a, b;
        int e24;
        logic o24;
        int e16;
        logic o16;
    } vec_t;

    vec_t tv [5];

    initial begin
        logic [23:0] r24;
        logic [15:0] r16;
        logic o24, o16;
        longint sum;
        int n, bad;
        tv[0] = '{1, 0, 0, 32'h00000003, 32'h00000005, 15, 1'b0, 15, 1'b0};
        tv[1] = '{4, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 260100, 1'b0, 63492, 1'b1};
        tv[2] = '{0, 0, 2, 32'h00000000, 32'h00000000, 0, 1'b0, 0, 1'b0};
        tv[3] = '{2, 0, 0, 32'h0000FFFF, 32'h0000FFFF, 130050, 1'b0, 64514, 1'b1};
        tv[4] = '{3, 1, 5, 32'h00018007, 32'h00010209, 320, 1'b0, 320, 1'b0};
        rst_n = 1'b0; start = 1'b0; len = 8'd0; abort = 1'b0;
        in_valid = 1'b1; in_a = 8'hA5; in_b = 8'h5A; out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_outs", {out_valid, in_ready, busy, out_ovf}, 0);
        chk("rst_acc", out_acc, 0);
        chk("rst_pp", {pp8, pp7, pp6, pp5, pp4, pp3, pp2, pp1}, 0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        for (int t = 0; t < 5; t++) begin
            for (int k = 0; k < 4; k++) begin
                ja[k] = tv[t].a[8*k+:8];
                jb[k] = tv[t].b[8*k+:8];
            end
            run_job(tv[t].n, tv[t].gap, tv[t].hold, 1'b0, r24, o24, r16, o16);
            chk("acc24", r24, tv[t].e24);
            chk("ovf24", o24, tv[t].o24);
            chk("acc16", r16, tv[t].e16);
            chk("ovf16", o16, tv[t].o16);
            chk("ovf_sticky", out_ovf_h, tv[t].o16);
        end

        // abort after two accepts; a simultaneous handshake and out_ready must be dropped
        start = 1'b1; len = 8'd4;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_a = 8'd200; in_b = 8'd200;
        repeat (2) tick();
        abort = 1'b1; out_ready = 1'b1;
        tick();
        abort = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        chk("abort_state", {busy, in_ready, out_valid, busy_h}, 0);
        chk("abort_clear", {out_acc, pp8, pp1, out_acc_h}, 0);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid || busy) bad++;
        end
        chk("abort_quiet", bad, 0);
        ja[0] = 8'd2; jb[0] = 8'd3;
        run_job(1, 0, 0, 1'b0, r24, o24, r16, o16);
        chk("post_abort_acc", r24, 6);
        chk("post_abort_acc16", r16, 6);

        for (int j = 0; j < 25; j++) begin
            n = $urandom_range(1, 12);
            sum = 0;
            for (int k = 0; k < n; k++) begin
                ja[k] = $urandom_range(0, 3) == 0 ? 8'hFF : 8'($urandom);
                jb[k] = $urandom_range(0, 3) == 0 ? 8'hFF : 8'($urandom);
                sum += longint'(ja[k]) * longint'(jb[k]);
            end
            run_job(n, -1, $urandom_range(0, 3), 1'b1, r24, o24, r16, o16);
            chk("rnd_acc24", r24, 64'(sum % (64'd1 << 24)));
            chk("rnd_ovf24", o24, sum >= (64'd1 << 24));
            chk("rnd_acc16", r16, 64'(sum % (64'd1 << 16)));
            chk("rnd_ovf16", o16, sum >= (64'd1 << 16));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
